// File: rtl/gpu_write_buffer.sv
// CPU-side write buffer: queues VRAM byte writes and drains them one per cycle to the graphics card.
// Build option GPU_WB_VBLANK_ONLY_EN restricts draining to blanking (video_enable low).
module gpu_write_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_we,
    input  logic [15:0]                  cpu_addr,
    input  logic [7:0]                   cpu_data,
    input  logic                         cpu_io_we,
    input  logic [15:0]                  cpu_io_data,
    input  logic                         ovf_clr,
    input  logic                         video_enable,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         gpu_write_en,
    output logic [15:0]                  cpu_write_address,
    output logic [7:0]                   cpu_write_data,
    output logic [15:0]                  io_data
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } entry_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    entry_t     mem [DEPTH];
    entry_t     head;
    logic [AW:0] wptr, rptr;
    logic       empty, permit, push, pop, drop;
    state_t     state;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign level = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

`ifdef GPU_WB_VBLANK_ONLY_EN
    assign permit = ~video_enable;
`else
    assign permit = 1'b1;
`endif

    // Push and pop both look at registered occupancy, so a pop never frees room for a same-edge push.
    assign push = cpu_we & ~full;
    assign drop = cpu_we & full;
    assign pop  = ~empty & permit;
    assign head = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= '{addr: cpu_addr, data: cpu_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           io_data <= '0;
        else if (cpu_io_we) io_data <= cpu_io_data;
    end

    // Drain FSM; the output registers keep the last issued entry while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            gpu_write_en      <= 1'b0;
            cpu_write_address <= '0;
            cpu_write_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state             <= ISSUE;
                        gpu_write_en      <= 1'b1;
                        cpu_write_address <= head.addr;
                        cpu_write_data    <= head.data;
                    end else begin
                        gpu_write_en <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (pop) begin
                        gpu_write_en      <= 1'b1;
                        cpu_write_address <= head.addr;
                        cpu_write_data    <= head.data;
                    end else begin
                        state        <= IDLE;
                        gpu_write_en <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    gpu_write_en <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_write_buffer.sv
// Randomized bench for gpu_write_buffer against a queue-based reference model.
// Blocks needing held-off drain run only when GPU_WB_VBLANK_ONLY_EN is defined.
module tb_gpu_write_buffer;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_we, cpu_io_we, ovf_clr, video_enable;
    logic [15:0]   cpu_addr, cpu_io_data;
    logic [7:0]    cpu_data;
    logic          full, overflow, gpu_write_en;
    logic [LW-1:0] level;
    logic [15:0]   cpu_write_address, io_data;
    logic [7:0]    cpu_write_data;

    gpu_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_io_we(cpu_io_we), .cpu_io_data(cpu_io_data),
        .ovf_clr(ovf_clr), .video_enable(video_enable),
        .full(full), .level(level), .overflow(overflow),
        .gpu_write_en(gpu_write_en), .cpu_write_address(cpu_write_address),
        .cpu_write_data(cpu_write_data), .io_data(io_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: a queue of {addr,data} plus the expected visible registers.
    logic [23:0] q[$];
    logic        m_en, m_ovf;
    logic [15:0] m_addr, m_io;
    logic [7:0]  m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"}, 32'(level), 32'(q.size()));
        check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".en"}, 32'(gpu_write_en), 32'(m_en));
        check({tag, ".addr"}, 32'(cpu_write_address), 32'(m_addr));
        check({tag, ".data"}, 32'(cpu_write_data), 32'(m_data));
        check({tag, ".io"}, 32'(io_data), 32'(m_io));
    endtask

    task automatic model_reset();
        q.delete();
        m_en = 0; m_ovf = 0; m_addr = 0; m_data = 0; m_io = 0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input string tag, input logic we, input logic [15:0] a, input logic [7:0] d,
                        input logic iowe, input logic [15:0] iod, input logic clr, input logic ven);
        logic perm;
        int   sz;
        logic [23:0] e;
        cpu_we = we; cpu_addr = a; cpu_data = d;
        cpu_io_we = iowe; cpu_io_data = iod; ovf_clr = clr; video_enable = ven;
        @(posedge clk);
`ifdef GPU_WB_VBLANK_ONLY_EN
        perm = !ven;
`else
        perm = 1'b1;
`endif
        sz = q.size();
        if (sz > 0 && perm) begin
            e = q.pop_front();
            m_en = 1; m_addr = e[23:8]; m_data = e[7:0];
        end else begin
            m_en = 0;
        end
        if (we && sz < DEPTH) q.push_back({a, d});
        if (we && sz == DEPTH) m_ovf = 1;
        else if (clr)          m_ovf = 0;
        if (iowe) m_io = iod;
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic ven);
        step(tag, 0, 16'h0, 8'h0, 0, 16'h0, 0, ven);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        cpu_we = 0; cpu_addr = 0; cpu_data = 0; cpu_io_we = 0; cpu_io_data = 0;
        ovf_clr = 0; video_enable = 0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b1;

        // Single write: strobe one cycle after the push, level back to 0.
        step("single_push", 1, 16'h1234, 8'hA5, 0, 0, 0, 0);
        check("single_lvl1", 32'(level), 32'd1);
        idle("single_issue", 0);
        check("single_en", 32'(gpu_write_en), 32'd1);
        check("single_addr", 32'(cpu_write_address), 32'h1234);
        check("single_data", 32'(cpu_write_data), 32'hA5);
        check("single_lvl0", 32'(level), 32'd0);
        idle("single_hold", 0);
        check("single_held", 32'(cpu_write_address), 32'h1234);

`ifdef GPU_WB_VBLANK_ONLY_EN
        // Fill with drain held off, then drop with a coinciding clear.
        for (int i = 0; i < DEPTH + 1; i++)
            step("fill", 1, 16'(16'h100 + i), 8'(i), 0, 0, 0, 1);
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'(DEPTH));
        check("fill_ovf", 32'(overflow), 32'd1);
        step("drop_clr", 1, 16'hDEAD, 8'hEE, 0, 0, 1, 1);
        check("drop_clr_ovf", 32'(overflow), 32'd1);
        step("io_full", 0, 0, 0, 1, 16'hBEEF, 0, 1);
        check("io_val", 32'(io_data), 32'hBEEF);
        check("io_lvl", 32'(level), 32'(DEPTH));
        step("ovf_clr", 0, 0, 0, 0, 0, 1, 1);
        check("ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            idle("drain", 0);
            check("drain_order", 32'(cpu_write_address), 32'(16'h100 + i));
        end
        idle("drain_done", 0);

        // Build level 3, then push every cycle while draining.
        for (int i = 0; i < 3; i++) step("pre3", 1, 16'(16'h200 + i), 8'(i), 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step("simul", 1, 16'(16'h300 + i), 8'(i), 0, 0, 0, 0);
            check("simul_lvl", 32'(level), 32'd3);
        end
        for (int i = 0; i < 5; i++) idle("simul_flush", 0);
`else
        step("io_only", 0, 0, 0, 1, 16'hBEEF, 0, 0);
        check("io_val", 32'(io_data), 32'hBEEF);
        for (int i = 0; i < 4; i++) begin
            step("simul", 1, 16'(16'h300 + i), 8'(i), 0, 0, 0, 1);
            check("simul_lvl", 32'(level), 32'd1);
        end
        idle("simul_flush", 0);
`endif

        // Sequential addresses across several pointer wraps.
        for (int i = 0; i < 40; i++) step("wrap", 1, 16'(i), 8'(i ^ 8'h5A), 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 2; i++) idle("wrap_flush", 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step("rand", ($urandom_range(0, 9) < 7), 16'($urandom), 8'($urandom),
                 ($urandom_range(0, 9) == 0), 16'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 4));
        end

        // Reset while entries are queued and draining.
        for (int i = 0; i < 5; i++) step("pre_rst", 1, 16'(16'h500 + i), 8'(i), 0, 0, 0, 1);
        step("mid_drain", 0, 0, 0, 0, 0, 0, 0);
        async_reset("rst_mid");
        for (int i = 0; i < 4; i++) begin
            idle("post_rst", 0);
            check("post_rst_en", 32'(gpu_write_en), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
